led_fade_pwm: RTL and testbench

- Downstream stage of the 4-LED one-hot chaser.
- Consumes the chaser's four LED levels and drives the physical LED pins with PWM.
- Each LED lights at full brightness while its input is high, then fades out stepwise after the input drops, leaving a "comet trail" behind the running light.
- Sits between the chaser outputs and the board pins; same clock domain as the chaser.

---
 rtl/led_fade_pwm_if.sv | 10 +
 rtl/led_fade_pwm.sv | 82 ++++++++
 tb/tb_led_fade_pwm.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/led_fade_pwm_if.sv
// Chaser-to-pin signal bundle for led_fade_pwm: LED levels in, PWM drive and activity flag out.
// There is no valid/ready handshake: led_in is a level, sampled on every clk edge, and the outputs are registered levels.
interface led_fade_pwm_if;
    logic [3:0] led_in;
    logic [3:0] pwm_out;
    logic       active;

    modport master (output led_in, input pwm_out, input active);
    modport slave  (input led_in, output pwm_out, output active);
endinterface

// File: rtl/led_fade_pwm.sv
// Four-channel PWM LED driver with stepwise fade-out ("comet trail") behind a one-hot chaser.
// Define LED_FADE_GAMMA_EN for a squared (gamma) brightness curve; the default build maps level to duty linearly.
module led_fade_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 500000,
    parameter int DECAY_STEP = 16
) (
    input  logic           clk,
    input  logic           rst,
    led_fade_pwm_if.slave  io
);

    localparam int DIV_W = 25;
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] level [4];
    logic [PWM_BITS-1:0] duty  [4];
    logic [3:0]          pwm_q;
    logic                active_q;

    function automatic logic [PWM_BITS-1:0] map_level(input logic [PWM_BITS-1:0] lv);
`ifdef LED_FADE_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = (2*PWM_BITS)'(lv) * (2*PWM_BITS)'(lv);
        // Full brightness must stay fully on; the plain square would top out at MAX-1.
        if (lv == MAX) return MAX;
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return lv;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt  <= '0;
            div_cnt  <= '0;
            tick     <= 1'b0;
            pwm_q    <= '0;
            active_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                level[i] <= '0;
                duty[i]  <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);

            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
                tick    <= 1'b0;
            end

            for (int i = 0; i < 4; i++) begin
                // A driven input always wins over a coincident decay tick.
                if (io.led_in[i])
                    level[i] <= MAX;
                else if (tick)
                    level[i] <= (level[i] > STEP) ? level[i] - STEP : '0;

                // Duty only changes at the period boundary so no PWM period is cut short.
                if (pwm_cnt == MAX)
                    duty[i] <= map_level(level[i]);

                pwm_q[i] <= (duty[i] == MAX) | (pwm_cnt < duty[i]);
            end

            active_q <= (level[0] != '0) | (level[1] != '0) |
                        (level[2] != '0) | (level[3] != '0);
        end
    end

    assign io.pwm_out = pwm_q;
    assign io.active  = active_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: directed reset/fade/sweep phases plus random level patterns,
// every cycle compared against a cycle-indexed behavioural model.
module tb_led_fade_pwm;

    localparam int PB   = 8;
    localparam int DD   = 256;
    localparam int DS   = 64;
    localparam int MAXV = (1 << PB) - 1;
    localparam int PER  = 1 << PB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    led_fade_pwm_if io ();

    led_fade_pwm #(
        .PWM_BITS   (PB),
        .DECAY_DIV  (DD),
        .DECAY_STEP (DS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    // Behavioural model state: brightness and latched duty per channel, cycles since reset.
    int m_level [4];
    int m_duty  [4];
    int m_e;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q [$];
    int win_q [$];
    int hc;

    function automatic int map_ref(input int lv);
`ifdef LED_FADE_GAMMA_EN
        if (lv == MAXV) return MAXV;
        return (lv * lv) / PER;
`else
        return lv;
`endif
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // One clk cycle: apply inputs, predict the post-edge outputs, compare after the edge.
    task automatic step(input logic r, input logic [3:0] led);
        logic [4:0] exp;
        logic [4:0] got;
        logic [4:0] e;
        int pc;
        bit tk;
        int nl [4];
        int nd [4];
        pc = 0;
        @(negedge clk);
        rst       = r;
        io.led_in = led;
        exp = '0;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_level[i] = 0;
                m_duty[i]  = 0;
            end
            m_e = 0;
            hc  = 0;
        end else begin
            pc = m_e % PER;
            tk = (m_e > 0) && (m_e % DD == 0);
            exp[4] = (m_level[0] + m_level[1] + m_level[2] + m_level[3]) != 0;
            for (int i = 0; i < 4; i++) begin
                exp[i] = (m_duty[i] == MAXV) || (pc < m_duty[i]);
                nd[i] = (pc == MAXV) ? map_ref(m_level[i]) : m_duty[i];
                if (led[i])
                    nl[i] = MAXV;
                else if (tk)
                    nl[i] = (m_level[i] > DS) ? m_level[i] - DS : 0;
                else
                    nl[i] = m_level[i];
            end
            for (int i = 0; i < 4; i++) begin
                m_level[i] = nl[i];
                m_duty[i]  = nd[i];
            end
            m_e++;
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = {io.active, io.pwm_out};
        e = exp_q.pop_front();
        check("active", int'(got[4]), int'(e[4]));
        check("pwm_out", int'(got[3:0]), int'(e[3:0]));
        if (!r) begin
            hc += int'(got[2]);
            if (pc == MAXV) begin
                win_q.push_back(hc);
                hc = 0;
            end
        end
    endtask

    initial begin
        int fade_tbl [5];
        int len;
        logic [3:0] pat;
        fade_tbl = '{256, 191, 127, 63, 0};
        io.led_in = 4'b0000;
        hc = 0;

        // Reset held with all inputs high, then one cycle after release.
        repeat (3) step(1'b1, 4'b1111);
        step(1'b0, 4'b1111);
        repeat (20) step(1'b0, 4'b0000);

        // Single-cycle pulse on channel 2 then a full linear fade.
        step(1'b1, 4'b0000);
        win_q.delete();
        step(1'b0, 4'b0100);
        repeat (6 * PER - 1) step(1'b0, 4'b0000);
`ifndef LED_FADE_GAMMA_EN
        check("fade_windows", win_q.size(), 6);
        for (int k = 1; k < 6; k++)
            if (k < win_q.size()) check("fade_high_count", win_q[k], fade_tbl[k-1]);
`endif

        // Channel 1 held across a decay tick, then released to decay through saturation.
        step(1'b1, 4'b0000);
        repeat (300) step(1'b0, 4'b0010);
        repeat (1100) step(1'b0, 4'b0000);

        // Chaser sweep.
        step(1'b1, 4'b0000);
        for (int ch = 0; ch < 4; ch++)
            repeat (1024) step(1'b0, 4'(1 << ch));
        repeat (1024) step(1'b0, 4'b0000);

        // Random level patterns with occasional mid-fade reset.
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 9) == 0) step(1'b1, 4'($urandom_range(0, 15)));
            pat = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 400);
            repeat (len) step(1'b0, pat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
